// File: rtl/wave_sequencer.sv
// Wavetable playback sequencer: turns SPI commands into sample-rate read strobes and addresses.
// Optional macro CMD_SYNC_EN: cmd_valid is treated as asynchronous and edge-detected after a 2-flop synchronizer.
module wave_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 16,
  parameter int DIV0   = 1000,
  parameter int DIV1   = 500,
  parameter int DIV2   = 250,
  parameter int DIV3   = 125
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic [ADDR_W+1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              running,
  output logic              pending
);

  typedef enum logic [1:0] {IDLE = 2'd0, SWITCH = 2'd1, RUN = 2'd2} state_t;

  localparam logic [3:0]       STOP = 4'b1111;
  localparam logic [DIV_W-1:0] LIM0 = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] LIM1 = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] LIM2 = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] LIM3 = DIV_W'(DIV3 - 1);

  function automatic logic [DIV_W-1:0] div_lim(input logic [1:0] code);
    case (code)
      2'd0:    return LIM0;
      2'd1:    return LIM1;
      2'd2:    return LIM2;
      default: return LIM3;
    endcase
  endfunction

  state_t            state;
  logic [DIV_W-1:0]  divider;
  logic [ADDR_W-1:0] sample_idx;
  logic [ADDR_W-1:0] idx_next;
  logic [1:0]        wave;
  logic [1:0]        rate;
  logic [3:0]        pend_cmd;
  logic              cap;
  logic              in_run;
  logic              tick;
  logic              wrap_take;
  logic              consume;
  logic              do_switch;

`ifdef CMD_SYNC_EN
  logic vld_p0, vld_p1, vld_p2, strobe;

  // Stage boundary: two synchronizer flops, an edge-history flop and a registered capture strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      strobe <= 1'b0;
    end else begin
      vld_p0 <= cmd_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      strobe <= vld_p1 & ~vld_p2;
    end
  end

  assign cap = strobe;
`else
  assign cap = cmd_valid;
`endif

  assign idx_next = sample_idx + ADDR_W'(1);

  always_comb begin
    in_run    = (state != IDLE);
    tick      = in_run && (divider == div_lim(rate));
    // A held command is applied only where the wrap-to-zero tick would have been.
    wrap_take = tick && pending && (sample_idx == '1);
    consume   = (pending && !in_run) || wrap_take;
    do_switch = consume && (pend_cmd != STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      divider    <= '0;
      sample_idx <= '0;
      wave       <= '0;
      rate       <= '0;
      pend_cmd   <= '0;
      pending    <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      running    <= 1'b0;
    end else begin
      if (cap) begin
        pend_cmd <= cmd;
        pending  <= 1'b1;
      end else if (consume) begin
        pending  <= 1'b0;
      end

      if (do_switch) begin
        state      <= SWITCH;
        wave       <= pend_cmd[3:2];
        rate       <= pend_cmd[1:0];
        divider    <= '0;
        sample_idx <= '0;
        mem_addr   <= {pend_cmd[3:2], {ADDR_W{1'b0}}};
        mem_rd_en  <= 1'b1;
        running    <= 1'b1;
      end else if (wrap_take) begin
        state      <= IDLE;
        divider    <= '0;
        sample_idx <= '0;
        mem_addr   <= '0;
        mem_rd_en  <= 1'b0;
        running    <= 1'b0;
      end else if (tick) begin
        state      <= RUN;
        divider    <= '0;
        sample_idx <= idx_next;
        mem_addr   <= {wave, idx_next};
        mem_rd_en  <= 1'b1;
      end else begin
        if (in_run) begin
          state   <= RUN;
          divider <= divider + DIV_W'(1);
        end
        mem_rd_en <= 1'b0;
      end
    end
  end

endmodule
